// File: rtl/spi_reg_slave.sv
// SPI register responder clocked entirely by clk: oversampled ss/sck/sdin,
// command byte decode, burst access to three R/W registers plus a status byte.
module spi_reg_slave #(
  parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mlb,
  input  logic        ss,
  input  logic        sck,
  input  logic        sdin,
  input  logic [7:0]  stat_in,
  output logic        sdout,
  output logic        sdout_en,
  output logic [23:0] regs,
  output logic        wr_stb,
  output logic [1:0]  wr_addr,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t      state, state_n;
  logic [2:0]  ss_sync, sck_sync;
  logic [1:0]  sdin_sync;
  logic [7:0]  tx, tx_n, rx, rx_n, rx_byte;
  logic [2:0]  cnt, cnt_n;
  logic [1:0]  addr, addr_n, wr_addr_n;
  logic        is_wr, is_wr_n;
  logic [23:0] regs_n;
  logic        sdout_n, wr_stb_n, done_n, err_n;
  logic        ss_fall, ss_rise, sck_fall, sck_rise, byte_end;

  function automatic logic [7:0] mem_rd(input logic [1:0] a, input logic [23:0] r,
                                        input logic [7:0] s);
    case (a)
      2'd0:    mem_rd = r[7:0];
      2'd1:    mem_rd = r[15:8];
      2'd2:    mem_rd = r[23:16];
      default: mem_rd = s;
    endcase
  endfunction

  // Synchronizers are left unreset so a reset with ss held low shows no fresh fall.
  always_ff @(posedge clk) begin
    ss_sync   <= {ss_sync[1:0], ss};
    sck_sync  <= {sck_sync[1:0], sck};
    sdin_sync <= {sdin_sync[0], sdin};
  end

  assign ss_fall  = ss_sync[2] & ~ss_sync[1];
  assign ss_rise  = ~ss_sync[2] & ss_sync[1];
  assign sck_fall = sck_sync[2] & ~sck_sync[1];
  assign sck_rise = ~sck_sync[2] & sck_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 8'hFF;
      rx      <= 8'h00;
      cnt     <= 3'd0;
      addr    <= 2'd0;
      is_wr   <= 1'b0;
      regs    <= 24'h0;
      wr_addr <= 2'd0;
      wr_stb  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      sdout   <= 1'b1;
    end else begin
      state   <= state_n;
      tx      <= tx_n;
      rx      <= rx_n;
      cnt     <= cnt_n;
      addr    <= addr_n;
      is_wr   <= is_wr_n;
      regs    <= regs_n;
      wr_addr <= wr_addr_n;
      wr_stb  <= wr_stb_n;
      done    <= done_n;
      err     <= err_n;
      sdout   <= sdout_n;
    end
  end

  assign sdout_en = (state != IDLE);

  always_comb begin
    state_n   = state;
    tx_n      = tx;
    rx_n      = rx;
    cnt_n     = cnt;
    addr_n    = addr;
    is_wr_n   = is_wr;
    regs_n    = regs;
    wr_addr_n = wr_addr;
    wr_stb_n  = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    rx_byte   = mlb ? {rx[6:0], sdin_sync[1]} : {sdin_sync[1], rx[7:1]};
    byte_end  = sck_rise && (cnt == 3'd7);
    // sdout lags tx by one register so it moves on the 4th clk after an sck fall
    sdout_n   = (state == IDLE) ? 1'b1 : (mlb ? tx[7] : tx[0]);

    case (state)
      IDLE: begin
        cnt_n = 3'd0;
        if (ss_fall) begin
          tx_n    = STATUS_BYTE;
          state_n = CMD;
        end
      end
      CMD, DATA: begin
        if (sck_rise) begin
          rx_n  = rx_byte;
          cnt_n = cnt + 3'd1;
        end else if (sck_fall && cnt != 3'd0) begin
          tx_n = mlb ? {tx[6:0], 1'b1} : {1'b1, tx[7:1]};
        end

        if (byte_end) begin
          done_n = 1'b1;
          if (state == CMD) begin
            addr_n  = rx_byte[1:0];
            is_wr_n = rx_byte[7];
            tx_n    = rx_byte[7] ? 8'hFF : mem_rd(rx_byte[1:0], regs, stat_in);
            state_n = DATA;
          end else begin
            if (is_wr && addr != 2'd3) begin
              wr_stb_n  = 1'b1;
              wr_addr_n = addr;
              case (addr)
                2'd0:    regs_n[7:0]   = rx_byte;
                2'd1:    regs_n[15:8]  = rx_byte;
                default: regs_n[23:16] = rx_byte;
              endcase
            end
            addr_n = addr + 2'd1;
            tx_n   = is_wr ? 8'hFF : mem_rd(addr + 2'd1, regs, stat_in);
          end
        end

        // A byte finishing in the same cycle as deselect still counts as whole.
        if (ss_rise) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
          err_n   = (cnt != 3'd0) && !byte_end;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: behavioural SPI master, directed scenarios and
// randomized bursts checked against a register-map model.
module tb_spi_reg_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mlb = 1'b1;
  logic        ss = 1'b1;
  logic        sck = 1'b1;
  logic        sdin = 1'b1;
  logic [7:0]  stat_in = 8'h00;
  logic        sdout, sdout_en, wr_stb, done, err;
  logic [23:0] regs;
  logic [1:0]  wr_addr;

  spi_reg_slave #(.STATUS_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .mlb(mlb), .ss(ss), .sck(sck), .sdin(sdin),
    .stat_in(stat_in), .sdout(sdout), .sdout_en(sdout_en), .regs(regs),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int half = 5;
  int doneCnt = 0, wrCnt = 0, errCnt = 0;
  logic [1:0] wrAddrQ[$];
  logic [7:0] mosiQ[$], misoQ[$], expQ[$];
  logic [1:0] expAddrQ[$];
  logic [7:0] refRegs[3];

  // Pulse monitor, sampled 2ns after the active edge.
  always begin
    @(posedge clk);
    #2;
    if (done) doneCnt++;
    if (err) errCnt++;
    if (wr_stb) begin
      wrCnt++;
      wrAddrQ.push_back(wr_addr);
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shiftByte(input logic [7:0] mosi, input int nb, output logic [7:0] miso);
    miso = 8'hFF;
    for (int i = 0; i < nb; i++) begin
      int idx;
      idx = mlb ? 7 - i : i;
      sck = 1'b0;
      sdin = mosi[idx];
      waitCycles(half);
      miso[idx] = sdout;
      sck = 1'b1;
      waitCycles(half);
    end
  endtask

  task automatic applyStimulus(input int lastBits);
    logic [7:0] got;
    misoQ.delete();
    ss = 1'b0;
    waitCycles(half + 2);
    for (int b = 0; b < mosiQ.size(); b++) begin
      shiftByte(mosiQ[b], (b == mosiQ.size() - 1) ? lastBits : 8, got);
      misoQ.push_back(got);
    end
    waitCycles(2);
    ss = 1'b1;
    sdin = 1'b1;
    waitCycles(half + 4);
  endtask

  // Reference: status byte first, then either 0xFF (write) or the addressed
  // register (read); the address walks mod 4 and address 3 is read-only.
  task automatic modelTransaction();
    logic       w;
    logic [1:0] a;
    expQ.delete();
    expAddrQ.delete();
    expQ.push_back(8'hA5);
    w = mosiQ[0][7];
    a = mosiQ[0][1:0];
    for (int k = 1; k < mosiQ.size(); k++) begin
      if (w) begin
        expQ.push_back(8'hFF);
        if (a != 2'd3) begin
          refRegs[a] = mosiQ[k];
          expAddrQ.push_back(a);
        end
      end else begin
        expQ.push_back((a == 2'd3) ? stat_in : refRegs[a]);
      end
      a = a + 2'd1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    waitCycles(5);
    total++; if (sdout !== 1'b1) begin bad++; $display("[TB] FAIL reset_sdout got=%b exp=1", sdout); end
    total++; if (sdout_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_sdout_en got=%b exp=0", sdout_en); end
    total++; if (regs !== 24'h0) begin bad++; $display("[TB] FAIL reset_regs got=%h exp=000000", regs); end
    total++; if ({wr_stb, wr_addr, done, err} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_pulses got=%b exp=00000", {wr_stb, wr_addr, done, err});
    end
    rst = 1'b0;
    waitCycles(6);
  endtask

  task automatic test_write_burst();
    int d0, w0, q0;
    logic [7:0] exp3[3];
    mlb = 1'b1; half = 5;
    d0 = doneCnt; w0 = wrCnt; q0 = wrAddrQ.size();
    mosiQ = '{8'h80, 8'h11, 8'h22};
    applyStimulus(8);
    exp3 = '{8'hA5, 8'hFF, 8'hFF};
    for (int k = 0; k < 3; k++) begin
      total++; if (misoQ[k] !== exp3[k]) begin bad++; $display("[TB] FAIL wb_miso%0d got=%h exp=%h", k, misoQ[k], exp3[k]); end
    end
    total++; if (regs !== 24'h002211) begin bad++; $display("[TB] FAIL wb_regs got=%h exp=002211", regs); end
    total++; if (wrCnt - w0 !== 2) begin bad++; $display("[TB] FAIL wb_wrcnt got=%0d exp=2", wrCnt - w0); end
    total++; if (doneCnt - d0 !== 3) begin bad++; $display("[TB] FAIL wb_done got=%0d exp=3", doneCnt - d0); end
    if (wrAddrQ.size() >= q0 + 2) begin
      total++; if ({wrAddrQ[q0], wrAddrQ[q0+1]} !== 4'b0001) begin
        bad++; $display("[TB] FAIL wb_wraddr got=%0d,%0d exp=0,1", wrAddrQ[q0], wrAddrQ[q0+1]);
      end
    end
  endtask

  task automatic test_read_wrap();
    int w0;
    logic [7:0] exp4[4];
    mlb = 1'b1;
    mosiQ = '{8'h80, 8'h11, 8'h22, 8'h33};
    applyStimulus(8);
    total++; if (regs !== 24'h332211) begin bad++; $display("[TB] FAIL rw_preload got=%h exp=332211", regs); end
    stat_in = 8'h5C;
    w0 = wrCnt;
    mosiQ = '{8'h02, 8'h00, 8'h00, 8'h00};
    applyStimulus(8);
    exp4 = '{8'hA5, 8'h33, 8'h5C, 8'h11};
    for (int k = 0; k < 4; k++) begin
      total++; if (misoQ[k] !== exp4[k]) begin bad++; $display("[TB] FAIL rw_miso%0d got=%h exp=%h", k, misoQ[k], exp4[k]); end
    end
    total++; if (wrCnt - w0 !== 0) begin bad++; $display("[TB] FAIL rw_nowrite got=%0d exp=0", wrCnt - w0); end
  endtask

  task automatic test_lsb_write();
    mlb = 1'b0;
    mosiQ = '{8'h82, 8'h3C};
    applyStimulus(8);
    total++; if (regs !== 24'h3C2211) begin bad++; $display("[TB] FAIL lsb_regs got=%h exp=3C2211", regs); end
    mosiQ = '{8'h02, 8'h00};
    applyStimulus(8);
    total++; if (misoQ[0] !== 8'hA5) begin bad++; $display("[TB] FAIL lsb_status got=%h exp=A5", misoQ[0]); end
    total++; if (misoQ[1] !== 8'h3C) begin bad++; $display("[TB] FAIL lsb_readback got=%h exp=3C", misoQ[1]); end
    mlb = 1'b1;
  endtask

  task automatic test_ro_drop();
    int d0, w0;
    d0 = doneCnt; w0 = wrCnt;
    mosiQ = '{8'h83, 8'hEE};
    applyStimulus(8);
    total++; if (wrCnt - w0 !== 0) begin bad++; $display("[TB] FAIL ro_wrstb got=%0d exp=0", wrCnt - w0); end
    total++; if (doneCnt - d0 !== 2) begin bad++; $display("[TB] FAIL ro_done got=%0d exp=2", doneCnt - d0); end
    total++; if (regs !== 24'h3C2211) begin bad++; $display("[TB] FAIL ro_regs got=%h exp=3C2211", regs); end
  endtask

  task automatic test_abort();
    int e0, w0;
    e0 = errCnt; w0 = wrCnt;
    mosiQ = '{8'h81, 8'h77};
    applyStimulus(5);
    total++; if (errCnt - e0 !== 1) begin bad++; $display("[TB] FAIL abort_err got=%0d exp=1", errCnt - e0); end
    total++; if (wrCnt - w0 !== 0) begin bad++; $display("[TB] FAIL abort_wrstb got=%0d exp=0", wrCnt - w0); end
    total++; if (regs !== 24'h3C2211) begin bad++; $display("[TB] FAIL abort_regs got=%h exp=3C2211", regs); end
    mosiQ = '{8'h81, 8'h44};
    applyStimulus(8);
    total++; if (misoQ[0] !== 8'hA5) begin bad++; $display("[TB] FAIL abort_next_status got=%h exp=A5", misoQ[0]); end
    total++; if (regs !== 24'h3C4411) begin bad++; $display("[TB] FAIL abort_next_regs got=%h exp=3C4411", regs); end
  endtask

  task automatic test_reset_mid();
    int d0, w0, e0;
    logic [7:0] got;
    mlb = 1'b1; half = 5;
    ss = 1'b0;
    waitCycles(half + 2);
    shiftByte(8'h80, 8, got);
    shiftByte(8'hAB, 3, got);
    total++; if (sdout_en !== 1'b1) begin bad++; $display("[TB] FAIL mid_selected got=%b exp=1", sdout_en); end
    rst = 1'b1;
    waitCycles(1);
    total++; if ({sdout, sdout_en, wr_stb, wr_addr, done, err} !== 7'b1000000) begin
      bad++; $display("[TB] FAIL mid_reset_outs got=%b exp=1000000", {sdout, sdout_en, wr_stb, wr_addr, done, err});
    end
    total++; if (regs !== 24'h0) begin bad++; $display("[TB] FAIL mid_reset_regs got=%h exp=000000", regs); end
    rst = 1'b0;
    d0 = doneCnt; w0 = wrCnt; e0 = errCnt;
    shiftByte(8'hCD, 8, got);
    shiftByte(8'h99, 8, got);
    total++; if (sdout_en !== 1'b0) begin bad++; $display("[TB] FAIL mid_stay_idle got=%b exp=0", sdout_en); end
    total++; if (doneCnt - d0 + wrCnt - w0 !== 0) begin
      bad++; $display("[TB] FAIL mid_no_response got=%0d exp=0", doneCnt - d0 + wrCnt - w0);
    end
    waitCycles(2);
    ss = 1'b1;
    waitCycles(half + 4);
    total++; if (errCnt - e0 !== 0) begin bad++; $display("[TB] FAIL mid_err got=%0d exp=0", errCnt - e0); end
    mosiQ = '{8'h80, 8'h5A};
    applyStimulus(8);
    total++; if (regs !== 24'h00005A) begin bad++; $display("[TB] FAIL mid_after_regs got=%h exp=00005A", regs); end
    total++; if (misoQ[0] !== 8'hA5) begin bad++; $display("[TB] FAIL mid_after_status got=%h exp=A5", misoQ[0]); end
  endtask

  task automatic test_random();
    int d0, w0, q0, n;
    refRegs[0] = 8'h5A; refRegs[1] = 8'h00; refRegs[2] = 8'h00;
    for (int t = 0; t < 20; t++) begin
      mlb = 1'($urandom_range(0, 1));
      half = $urandom_range(5, 8);
      stat_in = 8'($urandom);
      mosiQ.delete();
      mosiQ.push_back(8'($urandom));
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) mosiQ.push_back(8'($urandom));
      modelTransaction();
      d0 = doneCnt; w0 = wrCnt; q0 = wrAddrQ.size();
      applyStimulus(8);
      for (int k = 0; k <= n; k++) begin
        total++; if (misoQ[k] !== expQ[k]) begin
          bad++; $display("[TB] FAIL rnd%0d_miso%0d got=%h exp=%h", t, k, misoQ[k], expQ[k]);
        end
      end
      total++; if (regs !== {refRegs[2], refRegs[1], refRegs[0]}) begin
        bad++; $display("[TB] FAIL rnd%0d_regs got=%h exp=%h", t, regs, {refRegs[2], refRegs[1], refRegs[0]});
      end
      total++; if (doneCnt - d0 !== n + 1) begin bad++; $display("[TB] FAIL rnd%0d_done got=%0d exp=%0d", t, doneCnt - d0, n + 1); end
      total++; if (wrCnt - w0 !== expAddrQ.size()) begin
        bad++; $display("[TB] FAIL rnd%0d_wrcnt got=%0d exp=%0d", t, wrCnt - w0, expAddrQ.size());
      end else begin
        for (int k = 0; k < expAddrQ.size(); k++) begin
          total++; if (wrAddrQ[q0 + k] !== expAddrQ[k]) begin
            bad++; $display("[TB] FAIL rnd%0d_wraddr%0d got=%0d exp=%0d", t, k, wrAddrQ[q0 + k], expAddrQ[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_wrap();
    test_lsb_write();
    test_ro_drop();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

Fully synchronous SPI responder that gives the existing SPI master a register-mapped target: it oversamples `ss`, `sck` and `sdin` in the system clock domain and decodes a command/address byte. It then serves burst reads and writes to three R/W configuration registers and one read-only status register. It sits beside the user logic on the `clk` domain, so no logic runs on `sck`. Wire format matches the master:

- `sck` idles high.
- Data is sampled on the rising edge of `sck` and changed on the falling edge.
- Transfers are 8-bit, with bit order selected by `mlb`.

## Interface
- `STATUS_BYTE`, default 8'hA5: byte shifted out during every command byte.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mlb`  in  1  bit order: 1 = MSB first, 0 = LSB first. Static during a transaction.
- `ss`  in  1  active-low select from master (asynchronous).
- `sck`  in  1  serial clock from master (asynchronous).
- `sdin`  in  1  master-to-slave data (asynchronous).
- `stat_in`  in  8  value returned for address 3.
- `sdout`  out  1  slave-to-master data bit.
- `sdout_en`  out  1  1 while selected; the top level builds the tri-state from this.
- `regs`  out  24  `{reg2, reg1, reg0}` contents.
- `wr_stb`  out  1  one-cycle pulse when a register is written.
- `wr_addr`  out  2  address of that write; valid with `wr_stb`.
- `done`  out  1  one-cycle pulse per completed byte.
- `err`  out  1  one-cycle pulse when `ss` deasserts mid-byte.

## Operation
**Input synchronization**
- `ss`, `sck` and `sdin` each pass through 2 flip-flops, plus a third history flip-flop on `ss` and `sck`.
- A rise or fall is detected when the 2nd and 3rd stages differ.
- `sdin` is taken from its 2nd stage in the same cycle as the `sck` rise detection.

**States**
- IDLE:
  - `sdout_en`=0, `sdout`=1, bit counter = 0.
  - On a detected `ss` fall: load `tx` = `STATUS_BYTE`, go to CMD.
- CMD:
  - Shifts in the command byte.
  - Command format: bit7 = W (1 = write, 0 = read), bits[1:0] = start address, bits[6:2] ignored.
  - After the 8th rise: latch `addr`, latch W and pulse `done`.
  - If read, load `tx` = `mem[addr]`. If write, load `tx` = 8'hFF.
  - Go to DATA.
- DATA:
  - Each completed byte (8th rise) pulses `done`.
  - Write: `mem[addr]` = received byte, with `wr_stb`=1 and `wr_addr`=`addr` in the same cycle. Writes to address 3 are dropped (no `wr_stb`, still `done`).
  - Read: the byte just shifted out is `mem[addr]`.
  - Then `addr` = `addr`+1 (mod 4, so address 3 wraps to 0). Read reloads `tx` = `mem[new addr]`, write reloads `tx` = 8'hFF.
  - Bursts are unbounded.
- Any state:
  - A detected `ss` rise returns to IDLE.
  - If the bit counter is nonzero, pulse `err` and discard the partial byte; a partial write never commits.
- `mem[0..2]` = `regs`, `mem[3]` = `stat_in`, sampled at the load cycle.

**Shift rules**
- `sdout` always shows `tx[7]` when `mlb`=1, or `tx[0]` when `mlb`=0.
- On a detected `sck` rise, shift `sdin` into `rx`:
  - `mlb`=0: `rx` = `{sdin, rx[7:1]}`.
  - `mlb`=1: `rx` = `{rx[6:0], sdin}`.
  - Increment the 3-bit bit counter; 8 rises wrap it to 0.
- On a detected `sck` fall, shift `tx` only when the bit counter ≠ 0, filling with 1:
  - `mlb`=0: shift right.
  - `mlb`=1: shift left.
- This means the first fall of each byte presents the freshly loaded bit without shifting.
- `sck` edges while IDLE are ignored.

## Timing
- **Reset values:** `sdout`=1, `sdout_en`=0, `regs`=0, `wr_stb`=0, `wr_addr`=0, `done`=0, `err`=0, state IDLE, counters 0.
- **Pin-to-action latency:** a pin edge is acted on at the 3rd `clk` rise after it reaches the pin. `sdout` changes on the 4th `clk` rise after the `sck` fall.
- **Minimum `sck` half-period:** 4 `clk` cycles, i.e. master `cdiv` ≥ 2'b01. `cdiv`=2'b00 is unsupported.
- **Write visibility:** `wr_stb`, `done` and the new `regs` value all appear in the cycle after the 8th `sck` rise is detected.
- **Simultaneous events:** an `ss` rise detected in the same cycle as an 8th-bit rise lets the byte complete (commit plus `done`), then the block goes to IDLE with no `err`.
- **Reset mid-transaction:** the block goes to IDLE. It does not re-enter CMD until a fresh `ss` fall is seen after reset; if `ss` is still low, it waits for the rise.

## Test plan
- **Write burst:** reset; master (`cdiv`=01, `mlb`=1) sends 8'h80, 8'h11, 8'h22 in one `ss` window. Expect `regs`=24'h002211, `wr_stb` twice with `wr_addr` 0 then 1, `done` ×3, and the master receiving 8'hA5, 8'hFF, 8'hFF.
- **Read burst with wrap:** preload `regs`=24'h332211, `stat_in`=8'h5C; send 8'h02 then 3 dummy bytes. Expect the master to receive A5, 33, 5C, 11; `wr_stb` never asserts.
- **LSB-first write:** `mlb`=0, write 8'h3C to address 2. Expect `reg2`=8'h3C. A read back gives 8'h3C at the master.
- **Read-only drop:** write 8'hEE to address 3. Expect no `wr_stb`, `regs` unchanged, `done` ×2.
- **Abort:** raise `ss` after 5 bits of the data byte of a write to address 1. Expect an `err` pulse, `reg1` unchanged, and a following transaction decoding normally.
- **Reset mid-transaction:** assert `rst` for 1 cycle during the data byte with `ss` held low. Expect all outputs at reset values, no response until `ss` goes high then low again, then a normal write.
